// File: rtl/pmod_7led_rx.sv
// pmod_7led_rx: far-end receiver for the Pmod 8-digit 7-segment serial link.
// Rebuilds 16-bit line words from sclk/serial_data, latches them on rclk,
// checks framing and one-hot digit select, and keeps the segment image.
//
// Ports:
//   clk, rst_n    system clock, async active-low reset
//   sclk, rclk    shift / latch clocks from the driver (async to clk)
//   serial_data   serial data, MSB first
//   word_o        last correctly framed word
//   word_valid    1-cycle pulse when word_o updates
//   frame_err     1-cycle pulse on rclk rise with bit count != 16
//   onehot_err    1-cycle pulse when a framed word's digit field is not one-hot
//   seg_buf       segment image, active-low, digit n at [8n+7:8n]
//   frame_done    1-cycle pulse when the last digit is written
//   bit_cnt_o     current bit count (17 = overrun)

// Single-bit synchroniser chain.
module pmod_7led_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};

  assign q = ff[STAGES-1];
endmodule

module pmod_7led_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DIGITS      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  rclk,
  input  logic                  serial_data,
  output logic [15:0]           word_o,
  output logic                  word_valid,
  output logic                  frame_err,
  output logic                  onehot_err,
  output logic [8*DIGITS-1:0]   seg_buf,
  output logic                  frame_done,
  output logic [4:0]            bit_cnt_o
);
  localparam int NIN = 3;         // 2: sclk, 1: rclk, 0: serial_data
  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_OVR  = 5'd17;

  logic [NIN-1:0] pins, pins_s, pins_h;
  assign pins = {sclk, rclk, serial_data};

  for (genvar i = 0; i < NIN; i++) begin : g_sync
    pmod_7led_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pins[i]),
      .q     (pins_s[i])
    );
  end

  // Edge history: one more registered copy of the synchronised pins.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pins_h <= '0;
    else        pins_h <= pins_s;

  logic sclk_rise, rclk_rise, data_s;
  assign sclk_rise = pins_s[2] & ~pins_h[2];
  assign rclk_rise = pins_s[1] & ~pins_h[1];
  assign data_s    = pins_s[0];

  // Shift/count next-state; the latch decision looks at these so a shift
  // landing in the same cycle as a latch is counted before the check.
  logic [15:0] shreg, sh_nxt;
  logic [4:0]  bit_cnt, cnt_nxt;
  logic        latch_ok;

  always_comb begin
    sh_nxt  = shreg;
    cnt_nxt = bit_cnt;
    if (sclk_rise) begin
      sh_nxt  = {shreg[14:0], data_s};
      cnt_nxt = (bit_cnt == CNT_OVR) ? CNT_OVR : bit_cnt + 5'd1;
    end
  end

  assign latch_ok = rclk_rise && (cnt_nxt == CNT_FULL);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word_o     <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      shreg      <= sh_nxt;
      bit_cnt    <= rclk_rise ? 5'd0 : cnt_nxt;
      word_valid <= latch_ok;
      frame_err  <= rclk_rise && !latch_ok;
      if (latch_ok) word_o <= sh_nxt;
    end

  assign bit_cnt_o = bit_cnt;

  // Decode stage: runs the cycle after word_valid, from the registered word.
  logic [7:0] dig;
  logic [7:0] seg_pat;
  logic       onehot;
  assign dig     = word_o[7:0];
  assign seg_pat = word_o[15:8];
  assign onehot  = (dig != 8'd0) && ((dig & (dig - 8'd1)) == 8'd0);

  logic [DIGITS-1:0][7:0] seg_q;

  for (genvar n = 0; n < DIGITS; n++) begin : g_dig
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                              seg_q[n] <= 8'hFF;
      else if (word_valid && onehot && dig[n]) seg_q[n] <= seg_pat;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      onehot_err <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      onehot_err <= word_valid && !onehot;
      frame_done <= word_valid && onehot && dig[DIGITS-1];
    end

  assign seg_buf = seg_q;
endmodule

// File: tb/tb_pmod_7led_rx.sv
module tb_pmod_7led_rx;
  logic        clk, rst_n, sclk, rclk, serial_data;
  logic [15:0] word_o;
  logic        word_valid, frame_err, onehot_err, frame_done;
  logic [63:0] seg_buf;
  logic [4:0]  bit_cnt_o;

  pmod_7led_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .rclk        (rclk),
    .serial_data (serial_data),
    .word_o      (word_o),
    .word_valid  (word_valid),
    .frame_err   (frame_err),
    .onehot_err  (onehot_err),
    .seg_buf     (seg_buf),
    .frame_done  (frame_done),
    .bit_cnt_o   (bit_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observed pulse counts.
  int n_wv = 0, n_fe = 0, n_oh = 0, n_fd = 0;
  always @(negedge clk) if (rst_n) begin
    if (word_valid) n_wv++;
    if (frame_err)  n_fe++;
    if (onehot_err) n_oh++;
    if (frame_done) n_fd++;
  end

  // Reference model: bit history, count, last word, digit image, pulse tallies.
  bit [15:0] m_sh;
  int        m_cnt;
  bit [15:0] m_word;
  bit [7:0]  m_seg [8];
  int        e_wv = 0, e_fe = 0, e_oh = 0, e_fd = 0;

  task automatic model_reset();
    m_sh = 0; m_cnt = 0; m_word = 0;
    for (int n = 0; n < 8; n++) m_seg[n] = 8'hFF;
  endtask

  task automatic model_shift(input bit b);
    m_sh  = 16'((m_sh * 2) + b);
    m_cnt = (m_cnt < 17) ? m_cnt + 1 : 17;
  endtask

  task automatic model_latch();
    int ones, idx;
    if (m_cnt == 16) begin
      m_word = m_sh;
      e_wv++;
      ones = 0; idx = 0;
      for (int n = 0; n < 8; n++) if (m_sh[n]) begin ones++; idx = n; end
      if (ones == 1) begin
        m_seg[idx] = m_sh[15:8];
        if (idx == 7) e_fd++;
      end else e_oh++;
    end else e_fe++;
    m_cnt = 0;
  endtask

  function automatic logic [63:0] seg_img();
    logic [63:0] r;
    for (int n = 0; n < 8; n++) r[8*n +: 8] = m_seg[n];
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".word"}, 64'(word_o), 64'(m_word));
    chk({tag, ".seg"},  seg_buf, seg_img());
    chk({tag, ".cnt"},  64'(bit_cnt_o), 64'(m_cnt));
    chk({tag, ".wv"},   64'(n_wv), 64'(e_wv));
    chk({tag, ".fe"},   64'(n_fe), 64'(e_fe));
    chk({tag, ".oh"},   64'(n_oh), 64'(e_oh));
    chk({tag, ".fd"},   64'(n_fd), 64'(e_fd));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic latch(input string tag);
    rclk = 1'b1; wait_cyc(4);
    rclk = 1'b0; wait_cyc(4);
    model_latch();
    check_all(tag);
  endtask

  // Shift n bits of v MSB-first; with coinc, rclk rises with the last sclk.
  task automatic shift_bits(input int n, input logic [31:0] v, input bit coinc, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      serial_data = v[i];
      wait_cyc(4);
      sclk = 1'b1;
      if (coinc && i == 0) rclk = 1'b1;
      model_shift(v[i]);
      wait_cyc(4);
      sclk = 1'b0;
      if (coinc && i == 0) begin
        rclk = 1'b0;
        wait_cyc(6);
        model_latch();
        check_all(tag);
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    int len;
    bit co;
    rst_n = 1'b0; sclk = 1'b0; rclk = 1'b0; serial_data = 1'b0;
    model_reset();
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(5);
    check_all("reset");
    chk("reset.seg_const", seg_buf, 64'hFFFF_FFFF_FFFF_FFFF);

    shift_bits(16, 32'hC001, 1'b0, "single");
    latch("single");
    chk("single.seg0", 64'(seg_buf[7:0]), 64'hC0);

    for (int k = 0; k < 8; k++) begin
      d = 32'((k << 8) | (1 << k));
      shift_bits(16, d, 1'b0, "frame");
      latch("frame");
    end
    chk("frame.img", seg_buf, 64'h0706_0504_0302_0100);

    shift_bits(15, 32'h1234, 1'b0, "short");
    latch("short");

    shift_bits(20, 32'hABCDE, 1'b0, "ovr");
    chk("ovr.cnt17", 64'(bit_cnt_o), 64'd17);
    latch("ovr");

    shift_bits(16, 32'hAA00, 1'b0, "dig00");
    latch("dig00");
    shift_bits(16, 32'h5503, 1'b0, "dig03");
    latch("dig03");

    shift_bits(16, 32'h3C80, 1'b1, "coinc");

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0:       len = 15;
        1:       len = 17;
        2:       len = 20;
        default: len = 16;
      endcase
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[7:0] = 8'(1 << $urandom_range(0, 7));
      co = ($urandom_range(0, 4) == 0);
      shift_bits(len, d, co, "rand");
      if (!co) latch("rand");
    end

    shift_bits(8, 32'h5A, 1'b0, "midrst");
    rst_n = 1'b0;
    wait_cyc(2);
    model_reset();
    chk("midrst.word", 64'(word_o), 64'd0);
    chk("midrst.seg",  seg_buf, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("midrst.cnt",  64'(bit_cnt_o), 64'd0);
    chk("midrst.pulses", 64'({word_valid, frame_err, onehot_err, frame_done}), 64'd0);
    rst_n = 1'b1;
    wait_cyc(4);
    latch("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pmod_7led_rx.md
# pmod_7led_rx

Serial receiver for the Pmod 7-segment 8-digit display link. It is the far end of the `sclk`/`serial_data`/`rclk` chain driven by the display driver. It rebuilds each 16-bit line word, checks framing, and keeps an 8-digit segment image. It is used as an on-chip loopback checker and as a simulation model of the 74HC595 chain, so the driver can be verified without the board.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on each of `sclk`, `rclk`, `serial_data`; legal range 2..3.
- `DIGITS`, default 8: number of digits. Fixed at 8 for this revision.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `sclk` input 1: shift clock from the driver; asynchronous to `clk`.
- `rclk` input 1: latch clock from the driver; asynchronous to `clk`.
- `serial_data` input 1: serial data, MSB first.
- `word_o` output 16: last correctly framed word.
- `word_valid` output 1: one-cycle pulse when `word_o` updates.
- `frame_err` output 1: one-cycle pulse on an `rclk` rise with bit count ≠ 16.
- `onehot_err` output 1: one-cycle pulse when a framed word's digit field is not one-hot.
- `seg_buf` output 64: segment image, active-low; digit *n* is at `[8n+7:8n]`.
- `frame_done` output 1: one-cycle pulse when digit 7 is written.
- `bit_cnt_o` output 5: current bit count, for debug.

## Operation
- **Input synchronisation.** `sclk`, `rclk` and `serial_data` each pass through `SYNC_STAGES` flops. A rising edge is detected on the last stage against one further registered copy.
- **Shift.** On a detected `sclk` rise: `shreg <= {shreg[14:0], data_s}`. `data_s` is the synchronised `serial_data` sampled in the same cycle as the edge.
- **Bit count.** On each `sclk` rise, `bit_cnt` increments and saturates at 17. A value of 17 means overrun. `shreg` keeps the last 16 bits.
- **Latch.** On a detected `rclk` rise:
  - If `bit_cnt == 16`: `word_o <= shreg`, pulse `word_valid`, then decode the word.
  - Otherwise: pulse `frame_err`; `word_o` and `seg_buf` are unchanged.
  - In both cases `bit_cnt` clears to 0.
- **Word format.** `[15:8]` is the segment pattern `{dp,g,f,e,d,c,b,a}`, active-low. `[7:0]` is the digit select, one-hot, active-high; bit *n* selects digit *n*.
- **Decode** (in the cycle after `word_valid`):
  - Digit field exactly one-hot with bit *n* set: `seg_buf[8n+7:8n] <=` segment field. If *n* = 7, pulse `frame_done` in the same cycle.
  - Digit field zero or with more than one bit set: pulse `onehot_err`; `seg_buf` is unchanged.
- **Simultaneous events.** If `sclk` and `rclk` rises are detected in the same cycle, the shift and count update are applied first. The latch decision then uses the updated count and register, i.e. the shift is completed before the latch.
- **Reset values.** All outputs reset to 0, except `seg_buf`, which resets to all 1s (blank display). `shreg`, `bit_cnt`, the synchroniser flops and the edge-history flops all reset to 0.
- **Reset mid-frame.** Asserting `rst_n` aborts the partial word. After release, the first `rclk` rise gives `frame_err` unless 16 new bits have arrived.

## Timing
- **Shift latency.** An `sclk` pin rise reaches `shreg` `SYNC_STAGES+1` cycles later (3 at default).
- **Word latency.** An `rclk` pin rise gives `word_valid` after `SYNC_STAGES+1` cycles. `seg_buf`, `frame_done` and `onehot_err` follow one cycle after `word_valid`.
- **Input constraints.**
  - `sclk` high and low phases: each ≥ `SYNC_STAGES+1` `clk` cycles.
  - `serial_data`: stable from ≥ `SYNC_STAGES+1` cycles before an `sclk` rise until ≥ 1 cycle after it.
  - `rclk` high and low phases: each ≥ `SYNC_STAGES+1` cycles.
- **Pulses.** `word_valid`, `frame_err`, `onehot_err` and `frame_done` are each exactly one `clk` cycle wide, with no back-to-back merging. Back-to-back words are separated by at least 16 `sclk` periods, so consecutive pulses cannot overlap.
- **Status outputs.** `word_o`, `seg_buf` and `bit_cnt_o` are registered and hold their value between events.

## Test plan
- **Reset values.** Reset, then release.
  - Required: `seg_buf` = 64'hFFFF_FFFF_FFFF_FFFF; `word_o` = 0; `bit_cnt_o` = 0; no pulses.
- **Single word.** Shift 16'hC0_01 MSB-first, then `rclk`.
  - Required: `word_valid` once; `word_o` = 16'hC001; `seg_buf[7:0]` = 8'hC0; other digits stay FF.
- **Full frame.** Send 8 words, digits 0..7, segments 8'h00..8'h07.
  - Required: `seg_buf` = 64'h0706_0504_0302_0100; a single `frame_done` pulse after the 8th word.
- **Short frame and overrun.**
  - 15 bits then `rclk`: `frame_err`, no `word_valid`, `word_o` unchanged.
  - 20 bits then `rclk`: `frame_err`; `bit_cnt_o` = 17 before latch and 0 after.
- **Bad digit field.** Send words with digit fields 8'h00 and 8'h03.
  - Required: `word_valid` then `onehot_err` for each; `seg_buf` unchanged.
- **Coincident 16th bit and latch.** Assert `rclk` on the same `clk` edge as the 16th `sclk` rise.
  - Required: `word_valid` and the correct word.
- **Reset mid-frame.** Assert `rst_n` after bit 8.
  - Required: all outputs return to their reset values.
